sa_row_load_ctrl: RTL and testbench

//  Loads one ROW x COL weight tile into the systolic-array row registers, then runs one compute window.
//  - Accepts a row-major word stream over valid/ready.
//  - For each accepted word, drives a one-hot row write-enable plus column index and data.
//  - Asserts o_compute_en for COMPUTE_CYCLES, then pulses o_done.
//  - Sits between the host/DMA stream and the array's row-enable / weight-write inputs.

---
 rtl/sa_ctrl_pkg.sv | 19 +
 rtl/sa_wrap_counter.sv | 39 +++
 rtl/sa_row_load_ctrl.sv | 134 +++++++++++++
 tb/tb_sa_row_load_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array row load controller.
package sa_ctrl_pkg;

   // Controller states; the encodings are fixed so waveforms and any
   // software-visible state dumps read the same across builds.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      FLUSH   = 3'd2,
      COMPUTE = 3'd3,
      DONE    = 3'd4
   } state_t;

   // Counter/index width: a 1-entry range still needs a 1-bit port.
   function automatic int cw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sa_wrap_counter.sv
// Modulo-MAX up counter with synchronous clear and a wrap flag that is
// high in the cycle the counter steps from MAX-1 back to 0.
module sa_wrap_counter
   import sa_ctrl_pkg::*;
#(
   parameter int MAX = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   output logic [cw(MAX)-1:0] count,
   output logic              wrap
);

   localparam int W = cw(MAX);

   generate
      if (MAX == 1) begin : g_const
         // Single-entry range: count is always 0 and every enable wraps.
         logic unused_ok;
         assign unused_ok = ^{clk, rst_n, clr};
         assign count     = '0;
         assign wrap      = en;
      end else begin : g_cnt
         // Count state: clear has priority over increment.
         always_ff @(posedge clk) begin
            if (!rst_n)
               count <= '0;
            else if (clr)
               count <= '0;
            else if (en)
               count <= (count == W'(MAX - 1)) ? '0 : count + W'(1);
         end
         assign wrap = en && (count == W'(MAX - 1));
      end
   endgenerate

endmodule

// File: rtl/sa_row_load_ctrl.sv
// Loads a ROW x COL weight tile from a valid/ready stream into the array
// row registers, then runs one COMPUTE_CYCLES compute window and pulses done.
module sa_row_load_ctrl
   import sa_ctrl_pkg::*;
#(
   parameter int ROW            = 9,
   parameter int COL            = 9,
   parameter int DATA_W         = 8,
   parameter int COMPUTE_CYCLES = 17
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic                i_s_valid,
   output logic                o_s_ready,
   input  logic [DATA_W-1:0]   i_s_data,
   output logic [ROW-1:0]      o_row_we,
   output logic [cw(COL)-1:0]  o_col_idx,
   output logic [DATA_W-1:0]   o_wr_data,
   output logic                o_compute_en,
   output logic                o_busy,
   output logic                o_done
);

   localparam int CW_R = cw(ROW);
   localparam int CW_C = cw(COL);
   localparam int CW_K = cw(COMPUTE_CYCLES);
   localparam logic [ROW-1:0] ROW_ONE = ROW'(1);

   state_t           state, state_nxt;
   logic             accept;
   logic             cnt_clr;
   logic             cmp_en;
   logic [CW_C-1:0]  col_cnt;
   logic [CW_R-1:0]  row_cnt;
   logic [CW_K-1:0]  unused_cmp_cnt;   // only the wrap flag ends the window
   logic             col_wrap, row_wrap, cmp_wrap;

   // Ready is purely a state decode, so accept never depends on a stale flag.
   assign accept  = i_s_valid && (state == LOAD);
   assign cmp_en  = (state == COMPUTE);
   // Counters already wrap back to 0 on their own; the DONE clear also
   // covers any leftover count so every tile starts at row 0, col 0.
   assign cnt_clr = (state == DONE);

   sa_wrap_counter #(.MAX(COL)) u_col (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (accept),
      .clr   (cnt_clr),
      .count (col_cnt),
      .wrap  (col_wrap)
   );

   sa_wrap_counter #(.MAX(ROW)) u_row (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (col_wrap),
      .clr   (cnt_clr),
      .count (row_cnt),
      .wrap  (row_wrap)
   );

   sa_wrap_counter #(.MAX(COMPUTE_CYCLES)) u_cmp (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (cmp_en),
      .clr   (cnt_clr),
      .count (unused_cmp_cnt),
      .wrap  (cmp_wrap)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic and state-decoded control outputs.
   always_comb begin
      state_nxt    = state;
      o_s_ready    = 1'b0;
      o_compute_en = 1'b0;
      o_busy       = 1'b1;
      o_done       = 1'b0;
      case (state)
         IDLE: begin
            o_busy = 1'b0;
            if (i_start)
               state_nxt = LOAD;
         end
         LOAD: begin
            o_s_ready = 1'b1;
            // row_wrap implies an accept of the last column of the last row.
            if (row_wrap)
               state_nxt = FLUSH;
         end
         FLUSH: begin
            state_nxt = COMPUTE;
         end
         COMPUTE: begin
            o_compute_en = 1'b1;
            if (cmp_wrap)
               state_nxt = DONE;
         end
         DONE: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Write port: one-hot row strobe for one cycle per accepted word, with the
   // column index and data captured alongside it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_row_we  <= '0;
         o_col_idx <= '0;
         o_wr_data <= '0;
      end else begin
         o_row_we <= accept ? (ROW_ONE << row_cnt) : '0;
         if (accept) begin
            o_col_idx <= col_cnt;
            o_wr_data <= i_s_data;
         end
      end
   end

endmodule

// File: tb/tb_sa_row_load_ctrl.sv
// Self-checking bench for sa_row_load_ctrl: table-driven tiles checked
// cycle by cycle against a timeline model, plus reset and 1x1 sequences.
module tb_sa_row_load_ctrl;
   import sa_ctrl_pkg::*;

   localparam int ROW = 3;
   localparam int COL = 2;
   localparam int DW  = 8;
   localparam int CC  = 4;
   localparam int RC  = ROW * COL;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic                start, s_valid, s_ready;
   logic [DW-1:0]       s_data;
   logic [ROW-1:0]      row_we;
   logic [cw(COL)-1:0]  col_idx;
   logic [DW-1:0]       wr_data;
   logic                compute_en, busy, done;

   logic                e_start, e_valid, e_ready;
   logic [DW-1:0]       e_data;
   logic [0:0]          e_row_we;
   logic [0:0]          e_col_idx;
   logic [DW-1:0]       e_wr_data;
   logic                e_ce, e_busy, e_done;

   sa_row_load_ctrl #(.ROW(ROW), .COL(COL), .DATA_W(DW), .COMPUTE_CYCLES(CC)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_s_valid(s_valid),
      .o_s_ready(s_ready), .i_s_data(s_data), .o_row_we(row_we),
      .o_col_idx(col_idx), .o_wr_data(wr_data), .o_compute_en(compute_en),
      .o_busy(busy), .o_done(done)
   );

   sa_row_load_ctrl #(.ROW(1), .COL(1), .DATA_W(DW), .COMPUTE_CYCLES(CC)) dut_e (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(e_start), .i_s_valid(e_valid),
      .o_s_ready(e_ready), .i_s_data(e_data), .o_row_we(e_row_we),
      .o_col_idx(e_col_idx), .o_wr_data(e_wr_data), .o_compute_en(e_ce),
      .o_busy(e_busy), .o_done(e_done)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int cyc, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
      end
   endtask

   // Structural invariants on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if ((|row_we && compute_en) || ($countones(row_we) > 1) ||
             (s_ready && (!busy || compute_en || done))) begin
            errors++;
            $display("FAIL invariant t=%0t we=%b ce=%b rdy=%b busy=%b done=%b",
                     $time, row_we, compute_en, s_ready, busy, done);
         end
      end
   end

   typedef struct {
      logic [63:0] vmask;    // bit c: i_s_valid in cycle c (1 beyond bit 63)
      logic [63:0] smask;    // bit c: extra i_start pulse in cycle c
      int          exp_done; // cycle of o_done relative to the start cycle; -1 = model only
      logic [7:0]  base;     // first word value
      string       name;
   } vec_t;

   vec_t tbl[6];

   // Runs one tile. The model derives the whole timeline from the accept
   // cycles: word j lands at acc[j]+1, compute spans L+2..L+1+CC, done at L+2+CC.
   task automatic run_tile(input vec_t t);
      int acc[$];
      int L, done_c, obs_done, nacc;
      logic v;
      logic [ROW-1:0] ew;
      logic [63:0] ecol, edat;
      acc = {};
      for (int c = 1; acc.size() < RC; c++)
         if (c > 63 || t.vmask[c]) acc.push_back(c);
      L        = acc[RC-1];
      done_c   = L + 2 + CC;
      obs_done = -1;
      for (int c = 0; c <= done_c + 2; c++) begin
         v    = (c > 63) ? 1'b1 : t.vmask[c];
         nacc = 0;
         foreach (acc[j]) if (acc[j] < c) nacc++;
         start   = (c == 0) || (c <= done_c && c < 64 && t.smask[c]);
         s_valid = v;
         s_data  = v ? t.base + 8'(nacc) : 8'($urandom);
         ew = '0; ecol = 0; edat = 0;
         foreach (acc[j]) if (acc[j] == c - 1) begin
            ew[j / COL] = 1'b1;
            ecol = 64'(j % COL);
            edat = 64'(8'(t.base + 8'(j)));
         end
         chk({t.name, ":ctl{rdy,busy,ce,done}"}, c, 64'({s_ready, busy, compute_en, done}),
             64'({c >= 1 && c <= L, c >= 1 && c <= done_c,
                  c >= L + 2 && c <= L + 1 + CC, c == done_c}));
         chk({t.name, ":row_we"}, c, 64'(row_we), 64'(ew));
         if (ew != '0) begin
            chk({t.name, ":col_idx"}, c, 64'(col_idx), ecol);
            chk({t.name, ":wr_data"}, c, 64'(wr_data), edat);
         end
         if (done && obs_done < 0) obs_done = c;
         @(posedge clk); #1;
      end
      start   = 1'b0;
      s_valid = 1'b0;
      if (t.exp_done >= 0)
         chk({t.name, ":done_cycle"}, 0, 64'(obs_done), 64'(t.exp_done));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nwe, nce, we_c, e_done_c;

      // Directed rows: back-to-back, 3-cycle stall after word 2, start while busy.
      tbl[0] = '{vmask: '1,          smask: 64'h0,   exp_done: 12, base: 8'h10, name: "stream"};
      tbl[1] = '{vmask: ~64'h38,     smask: 64'h0,   exp_done: 15, base: 8'h10, name: "stall"};
      tbl[2] = '{vmask: '1,          smask: 64'h208, exp_done: 12, base: 8'h10, name: "busy_start"};
      for (int i = 3; i < 6; i++) begin
         tbl[i].vmask    = {$urandom, $urandom} | {$urandom, $urandom};
         tbl[i].smask    = {$urandom, $urandom} & {$urandom, $urandom};
         tbl[i].exp_done = -1;
         tbl[i].base     = 8'($urandom);
         tbl[i].name     = $sformatf("rand%0d", i);
      end

      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
      e_start = 1'b0; e_valid = 1'b0; e_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_main", 0, 64'({row_we, col_idx, wr_data, compute_en, busy, done, s_ready}), 64'h0);
      chk("reset_edge", 0, 64'({e_row_we, e_col_idx, e_wr_data, e_ce, e_busy, e_done, e_ready}), 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_tile(tbl[i]);

      // Reset after word 3 has been accepted, then a clean restart.
      start = 1'b1; s_valid = 1'b1; s_data = 8'h10;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 3; n++) begin
         s_data = 8'h10 + 8'(n);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      chk("rst_mid_pre_we", 4, 64'(row_we), 64'b010);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_outputs", 5, 64'({row_we, col_idx, wr_data, compute_en, busy, done, s_ready}), 64'h0);
      rst_n = 1'b1;
      run_tile(tbl[0]);

      // 1x1 array: one word, one strobe, compute window, done.
      nwe = 0; nce = 0; we_c = -1; e_done_c = -1;
      for (int c = 0; c <= 10; c++) begin
         e_start = (c == 0);
         e_valid = (c <= 1);
         e_data  = (c <= 1) ? 8'hA5 : 8'h5A;
         if (e_row_we != 1'b0) begin
            nwe++; we_c = c;
            chk("edge_data", c, 64'({e_col_idx, e_wr_data}), 64'h0A5);
         end
         if (e_ce) nce++;
         if (e_done && e_done_c < 0) e_done_c = c;
         @(posedge clk); #1;
      end
      e_valid = 1'b0;
      chk("edge_we_count", 0, 64'(nwe), 64'd1);
      chk("edge_we_cycle", 0, 64'(we_c), 64'd2);
      chk("edge_ce_cycles", 0, 64'(nce), 64'(CC));
      chk("edge_done_cycle", 0, 64'(e_done_c), 64'(1 + 1 + 1 + CC + 1 - 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
